// File: rtl/ula_multiciclo_if.sv
// Start/done handshake and operand/result bus for the multicycle ALU.
// The datapath FSM is the master; the ALU is the slave.
interface ula_multiciclo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       controle;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] resultado;
    logic [WIDTH-1:0] hi;
    logic             cond;
    logic             zero;
    logic             overflow;
    logic             erro;

    modport master (
        output start, controle, a, b,
        input  busy, done, resultado, hi, cond, zero, overflow, erro
    );

    modport slave (
        input  start, controle, a, b,
        output busy, done, resultado, hi, cond, zero, overflow, erro
    );
endinterface

// File: rtl/ula_multiciclo.sv
// Execution-stage ALU: single-cycle ops plus iterative shift-add multiply
// and restoring divide, with a start/busy/done handshake.
module ula_multiciclo #(
    parameter int WIDTH = 32
) (
    input logic           clock,
    input logic           reset,
    ula_multiciclo_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

    localparam logic [1:0] OCIOSO = 2'd0;
    localparam logic [1:0] CALC   = 2'd1;
    localparam logic [1:0] FIM    = 2'd2;

    logic [1:0]       state;
    logic [SHW:0]     count;
    logic             op_div;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic [WIDTH-1:0] resultado;
    logic [WIDTH-1:0] hi;
    logic             cond;
    logic             zero;
    logic             overflow;
    logic             erro;

    logic [WIDTH-1:0] s_res;
    logic [WIDTH-1:0] s_hi;
    logic             s_cond;
    logic             s_ovf;
    logic             s_err;
    logic             it_op;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;

    logic [WIDTH:0]   m_add;
    logic [WIDTH:0]   d_sh;
    logic [WIDTH:0]   d_df;
    logic [WIDTH-1:0] n_hi;
    logic [WIDTH-1:0] n_lo;

    assign sum = bus.a + bus.b;
    assign dif = bus.a - bus.b;

    always_comb begin
        s_res  = '0;
        s_hi   = '0;
        s_cond = 1'b0;
        s_ovf  = 1'b0;
        s_err  = 1'b0;
        case (bus.controle)
            4'd0: begin
                s_res = sum;
                s_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                        (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd1: begin
                s_res = dif;
                s_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                        (dif[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'd2: s_res = bus.a & bus.b;
            4'd3: s_res = bus.a | bus.b;
            4'd4: s_res = ~bus.a;
            4'd5: s_res = bus.a << bus.b[SHW-1:0];
            4'd6: s_res = bus.a >> bus.b[SHW-1:0];
            4'd7: begin
                s_res  = dif;
                s_cond = (bus.a == bus.b);
            end
            4'd8: begin
                s_res  = dif;
                s_cond = (bus.a != bus.b);
            end
            4'd9: begin
                s_res  = dif;
                s_cond = bus.a[WIDTH-1];
            end
            4'd10: s_res = {{(WIDTH-1){1'b0}},
                            $signed(bus.a) < $signed(bus.b)};
            4'd11: s_res = {{(WIDTH-1){1'b0}},
                            $signed(bus.a) > $signed(bus.b)};
            4'd12: s_res = '0;
            // Only reached as a single-cycle op when dividing by zero
            4'd13: begin
                s_res = '1;
                s_hi  = bus.a;
                s_err = 1'b1;
            end
            default: s_err = 1'b1;
        endcase
    end

    assign it_op = (bus.controle == 4'd12) ||
                   ((bus.controle == 4'd13) && (bus.b != '0));

    always_comb begin
        m_add = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, rb} : '0);
        d_sh  = {acc_hi, acc_lo[WIDTH-1]};
        d_df  = d_sh - {1'b0, rb};
        if (op_div) begin
            if (!d_df[WIDTH]) begin
                n_hi = d_df[WIDTH-1:0];
                n_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                n_hi = d_sh[WIDTH-1:0];
                n_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            n_hi = m_add[WIDTH:1];
            n_lo = {m_add[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= OCIOSO;
            count     <= '0;
            op_div    <= 1'b0;
            rb        <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            resultado <= '0;
            hi        <= '0;
            cond      <= 1'b0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
            erro      <= 1'b0;
        end else begin
            case (state)
                OCIOSO: begin
                    if (bus.start) begin
                        if (it_op) begin
                            state  <= CALC;
                            count  <= CNT_INIT;
                            op_div <= (bus.controle == 4'd13);
                            rb     <= bus.b;
                            acc_hi <= '0;
                            acc_lo <= bus.a;
                        end else begin
                            state     <= FIM;
                            resultado <= s_res;
                            hi        <= s_hi;
                            cond      <= s_cond;
                            zero      <= (s_res == '0);
                            overflow  <= s_ovf;
                            erro      <= s_err;
                        end
                    end
                end
                CALC: begin
                    count <= count - 1'b1;
                    if (count == CNT_ONE) begin
                        state     <= FIM;
                        resultado <= n_lo;
                        hi        <= n_hi;
                        cond      <= 1'b0;
                        zero      <= (n_lo == '0);
                        overflow  <= 1'b0;
                        erro      <= 1'b0;
                    end else begin
                        acc_hi <= n_hi;
                        acc_lo <= n_lo;
                    end
                end
                FIM:     state <= OCIOSO;
                default: state <= OCIOSO;
            endcase
        end
    end

    assign bus.busy      = (state != OCIOSO);
    assign bus.done      = (state == FIM);
    assign bus.resultado = resultado;
    assign bus.hi        = hi;
    assign bus.cond      = cond;
    assign bus.zero      = zero;
    assign bus.overflow  = overflow;
    assign bus.erro      = erro;
endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed bench for ula_multiciclo: latency, results, flags, reset
// during iteration and handshake corner cases.
module tb_ula_multiciclo;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    ula_multiciclo_if #(.WIDTH(32)) bus ();

    ula_multiciclo #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic issue(input logic [3:0] c, input logic [31:0] x,
                         input logic [31:0] y);
        int g;
        g = 0;
        while (bus.busy && g < 100) begin
            @(posedge clock);
            #1;
            g++;
        end
        @(negedge clock);
        bus.start    = 1'b1;
        bus.controle = c;
        bus.a        = x;
        bus.b        = y;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        #12;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", bus.done); end
        total++; if (bus.resultado !== 32'h0 || bus.hi !== 32'h0) begin bad++; $display("FAIL rst_res got=%h/%h want=0/0", bus.resultado, bus.hi); end
        total++; if (bus.zero !== 1'b1 || bus.erro !== 1'b0) begin bad++; $display("FAIL rst_flags zero=%b erro=%b want=1/0", bus.zero, bus.erro); end
        @(negedge clock);
        reset = 1'b0;
        issue(4'd0, 32'd3, 32'd4);
        wait_done(n);
        total++; if (bus.resultado !== 32'd7) begin bad++; $display("FAIL pre_add got=%h want=7", bus.resultado); end
        issue(4'd12, 32'd5, 32'd6);
        repeat (10) begin @(posedge clock); #1; end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", bus.busy); end
        #1 reset = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL arst_hs busy=%b done=%b want=0/0", bus.busy, bus.done); end
        total++; if (bus.resultado !== 32'h0 || bus.zero !== 1'b1) begin bad++; $display("FAIL arst_res got=%h zero=%b want=0/1", bus.resultado, bus.zero); end
        @(negedge clock);
        reset = 1'b0;
        issue(4'd0, 32'd2, 32'd3);
        wait_done(n);
        total++; if (n !== 0 || bus.resultado !== 32'd5) begin bad++; $display("FAIL post_rst_add lat=%0d res=%h want=0/5", n, bus.resultado); end
    endtask

    task automatic test_add_sub();
        int n;
        issue(4'd0, 32'h7FFF_FFFF, 32'd1);
        wait_done(n);
        total++; if (n !== 0) begin bad++; $display("FAIL add_lat got=%0d want=0", n); end
        total++; if (bus.resultado !== 32'h8000_0000) begin bad++; $display("FAIL add_res got=%h want=80000000", bus.resultado); end
        total++; if (bus.overflow !== 1'b1 || bus.zero !== 1'b0) begin bad++; $display("FAIL add_flags ovf=%b zero=%b want=1/0", bus.overflow, bus.zero); end
        issue(4'd1, 32'd5, 32'd5);
        wait_done(n);
        total++; if (bus.resultado !== 32'h0 || bus.zero !== 1'b1 || bus.overflow !== 1'b0) begin bad++; $display("FAIL sub_eq res=%h zero=%b ovf=%b want=0/1/0", bus.resultado, bus.zero, bus.overflow); end
        issue(4'd1, 32'h8000_0000, 32'd1);
        wait_done(n);
        total++; if (bus.resultado !== 32'h7FFF_FFFF || bus.overflow !== 1'b1) begin bad++; $display("FAIL sub_ovf res=%h ovf=%b want=7fffffff/1", bus.resultado, bus.overflow); end
    endtask

    task automatic test_mult();
        int n;
        issue(4'd12, 32'hFFFF_FFFF, 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            bus.start = 1'b1; bus.controle = 4'd0; bus.a = 32'd1; bus.b = 32'd1;
            @(posedge clock);
            #1;
            bus.start = 1'b0;
        end
        wait_done(n);
        n = n + 5;
        total++; if (n !== 32) begin bad++; $display("FAIL mul_lat got=%0d want=32", n); end
        total++; if (bus.hi !== 32'h1 || bus.resultado !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mul_res got=%h_%h want=00000001_fffffffe", bus.hi, bus.resultado); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mul_fim_busy got=%b want=1", bus.busy); end
        @(negedge clock);
        bus.start = 1'b1; bus.controle = 4'd0; bus.a = 32'd1; bus.b = 32'd1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL fim_start done=%b busy=%b want=0/0", bus.done, bus.busy); end
        total++; if (bus.resultado !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mul_hold got=%h want=fffffffe", bus.resultado); end
    endtask

    task automatic test_div();
        int n;
        issue(4'd13, 32'd100, 32'd7);
        wait_done(n);
        total++; if (n !== 32) begin bad++; $display("FAIL div_lat got=%0d want=32", n); end
        total++; if (bus.resultado !== 32'd14 || bus.hi !== 32'd2) begin bad++; $display("FAIL div_res q=%0d r=%0d want=14/2", bus.resultado, bus.hi); end
        issue(4'd13, 32'hFFFF_FFFF, 32'h10);
        wait_done(n);
        total++; if (bus.resultado !== 32'h0FFF_FFFF || bus.hi !== 32'hF) begin bad++; $display("FAIL div_big q=%h r=%h want=0fffffff/f", bus.resultado, bus.hi); end
        issue(4'd13, 32'd9, 32'd0);
        wait_done(n);
        total++; if (n !== 0) begin bad++; $display("FAIL div0_lat got=%0d want=0", n); end
        total++; if (bus.resultado !== 32'hFFFF_FFFF || bus.hi !== 32'd9 || bus.erro !== 1'b1) begin bad++; $display("FAIL div0 res=%h hi=%h erro=%b want=ffffffff/9/1", bus.resultado, bus.hi, bus.erro); end
    endtask

    task automatic test_shift_set();
        int n;
        issue(4'd5, 32'd1, 32'h23);
        wait_done(n);
        total++; if (bus.resultado !== 32'd8) begin bad++; $display("FAIL sll got=%h want=8", bus.resultado); end
        issue(4'd6, 32'h8000_0000, 32'd31);
        wait_done(n);
        total++; if (bus.resultado !== 32'd1) begin bad++; $display("FAIL srl got=%h want=1", bus.resultado); end
        issue(4'd10, 32'hFFFF_FFFF, 32'd1);
        wait_done(n);
        total++; if (bus.resultado !== 32'd1) begin bad++; $display("FAIL slet got=%h want=1", bus.resultado); end
        issue(4'd11, 32'hFFFF_FFFF, 32'd1);
        wait_done(n);
        total++; if (bus.resultado !== 32'd0) begin bad++; $display("FAIL sgrt got=%h want=0", bus.resultado); end
        issue(4'd9, 32'h8000_0000, 32'd0);
        wait_done(n);
        total++; if (bus.cond !== 1'b1 || bus.resultado !== 32'h8000_0000) begin bad++; $display("FAIL blz cond=%b res=%h want=1/80000000", bus.cond, bus.resultado); end
        issue(4'd8, 32'd7, 32'd7);
        wait_done(n);
        total++; if (bus.cond !== 1'b0 || bus.zero !== 1'b1) begin bad++; $display("FAIL bneq cond=%b zero=%b want=0/1", bus.cond, bus.zero); end
        issue(4'd4, 32'h0F0F_0000, 32'd0);
        wait_done(n);
        total++; if (bus.resultado !== 32'hF0F0_FFFF || bus.cond !== 1'b0) begin bad++; $display("FAIL not res=%h cond=%b want=f0f0ffff/0", bus.resultado, bus.cond); end
    endtask

    task automatic test_illegal();
        int n;
        issue(4'b1110, 32'd12, 32'd34);
        wait_done(n);
        total++; if (n !== 0) begin bad++; $display("FAIL ill_lat got=%0d want=0", n); end
        total++; if (bus.erro !== 1'b1 || bus.resultado !== 32'h0 || bus.hi !== 32'h0) begin bad++; $display("FAIL ill erro=%b res=%h hi=%h want=1/0/0", bus.erro, bus.resultado, bus.hi); end
        issue(4'd0, 32'd1, 32'd1);
        wait_done(n);
        total++; if (bus.erro !== 1'b0 || bus.resultado !== 32'd2) begin bad++; $display("FAIL ill_clear erro=%b res=%h want=0/2", bus.erro, bus.resultado); end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0);
        wait_done(n);
        total++; if (n !== 0 || bus.resultado !== 32'h0F00_0F00) begin bad++; $display("FAIL b2b_and lat=%0d res=%h want=0/0f000f00", n, bus.resultado); end
        @(posedge clock);
        #1;
        issue(4'd3, 32'hF000_0000, 32'h0000_000F);
        total++; if (bus.done !== 1'b1 || bus.resultado !== 32'hF000_000F) begin bad++; $display("FAIL b2b_or done=%b res=%h want=1/f000000f", bus.done, bus.resultado); end
    endtask

    initial begin
        clock = 1'b0;
        reset = 1'b1;
        total = 0;
        bad   = 0;
        bus.start    = 1'b0;
        bus.controle = 4'd0;
        bus.a        = '0;
        bus.b        = '0;
        test_reset();
        test_add_sub();
        test_mult();
        test_div();
        test_shift_set();
        test_illegal();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ula_multiciclo.md
Name: ula_multiciclo

Overview:
- Execution-stage ALU that consumes the 4-bit ALU control code produced by the ALU-control decoder. It executes one operation per start request on two operands.
- Single-cycle ops complete in 1 cycle. mult/div run iteratively (shift-add / restoring) over WIDTH cycles.
- Provides a start/busy/done handshake so the datapath FSM stalls until the result is valid.

Parameters:
- WIDTH, 32, operand/result width; SHW = clog2(WIDTH) is a derived local constant.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request; accepted only in OCIOSO
- controle  in  4  operation code, sampled with start
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B, sampled with start
- busy  out  1  high from the accept cycle until done
- done  out  1  one-cycle pulse; results valid from this cycle onward
- resultado  out  WIDTH  main result: sum/logic/shift/set, mult low word, div quotient
- hi  out  WIDTH  mult high word, div remainder; 0 for other ops
- cond  out  1  branch condition for beq/bneq/blz; 0 for other ops
- zero  out  1  resultado == 0, registered with resultado
- overflow  out  1  signed overflow on add/sub; 0 otherwise
- erro  out  1  illegal code or divide by zero

Behaviour:
- Reset (async, any state, including mid-mult/div): state=OCIOSO; busy, done, cond, overflow, erro = 0; resultado = 0, hi = 0, zero = 1.
- FSM states: OCIOSO, CALC, FIM.
  - OCIOSO: on start, latch controle/a/b and raise busy. Single-cycle codes (including illegal codes and div with b==0) go to FIM with results registered at that edge. Codes 12/13 with valid operands go to CALC with count = WIDTH.
  - CALC: one iteration per cycle; decrement count; at count==1 the final step is registered and the FSM goes to FIM.
  - FIM: done=1 for exactly one cycle, busy=1; next state OCIOSO (busy=0).
- Latency: single-cycle op: start accepted at edge N, done high in cycle N+1. mult/div: done high in cycle N+WIDTH+1.
- start while busy is ignored: no queuing, no operand re-sample. start in the FIM cycle is also ignored.
- Outputs hold their last values until the next completion; they are updated only at the edge that enters FIM.
- Codes (a,b as latched):
  - 0 add: a+b, modulo 2^WIDTH.
  - 1 sub: a-b.
  - overflow for add/sub: sign(a)==sign(±b) and sign(res)!=sign(a).
  - 2 and, 3 or.
  - 4 not: ~a.
  - 5 sll: a << b[SHW-1:0]; 6 srl: logical a >> b[SHW-1:0]. Upper bits of b are ignored.
  - 7 beq: cond = (a==b). 8 bneq: cond = (a!=b). 9 blz: cond = a[WIDTH-1].
  - resultado for codes 7-9 is a-b.
  - 10 slet: resultado = (signed a < signed b) ? 1 : 0. 11 sgrt: signed a > signed b.
  - 12 mult: unsigned a*b; {hi,resultado} = full 2*WIDTH product.
  - 13 div: unsigned restoring division; resultado = a/b, hi = a%b.
  - div with b==0: single-cycle; resultado = all ones, hi = a, erro=1.
  - 14, 15, or any X/Z bit in controle: resultado=0, hi=0, erro=1, single-cycle.
- erro, cond, and overflow are cleared for each new operation unless that operation sets them.

Test Plan:
- Reset during CALC of mult (assert reset at iteration 10) -> busy=0, done=0, resultado=0, zero=1 immediately. A new start afterwards behaves normally.
- add a=0x7FFFFFFF, b=1 -> done at N+1, resultado=0x80000000, overflow=1, zero=0. sub a=5, b=5 -> resultado=0, zero=1, overflow=0.
- mult a=0xFFFFFFFF, b=2 -> done exactly at N+33, hi=0x00000001, resultado=0xFFFFFFFE. start pulses during busy are ignored and operands stay unchanged.
- div a=100, b=7 -> done at N+33, resultado=14, hi=2. div a=9, b=0 -> done at N+1, resultado=0xFFFFFFFF, hi=9, erro=1.
- sll a=1, b=0x23 -> resultado=8 (shift 3). slet a=0xFFFFFFFF, b=1 -> 1. sgrt with the same operands -> 0. blz a=0x80000000 -> cond=1.
- controle=4'b1110 -> erro=1, resultado=0, done at N+1. The next add clears erro. Back-to-back starts issued the cycle after done are both accepted.
